// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps a single-output combinational block through all 2^N_IN
// input codes, captures its truth table and compares it with a golden table.
// Optional feature macro: SEQ_STOP_ON_FAIL_EN ends the sweep at the first mismatching code.
module truth_table_sequencer #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_f,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic [N_IN:0]          mismatch_cnt,
  output logic [N_IN-1:0]        first_fail
);

  localparam int         N_VEC       = 1 << N_IN;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, HOLD, CAPTURE, FINISH} state_e;

  state_e             state_q, state_d;
  logic [N_IN-1:0]    idx_q, idx_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [N_VEC-1:0]   exp_q, exp_d;
  logic [N_VEC-1:0]   table_q, table_d;
  logic [N_IN:0]      mm_q, mm_d;
  logic [N_IN-1:0]    ff_q, ff_d;
  logic               pass_q, pass_d;
  logic               busy_q, busy_d;
  logic               miss;
  logic               last;
  logic               stop;

  assign miss = (dut_f != exp_q[idx_q]);
  assign last = &idx_q;

`ifdef SEQ_STOP_ON_FAIL_EN
  assign stop = last | miss;
`else
  assign stop = last;
`endif

  always_comb begin
    // NOTE: every next-state value is defaulted to its current value first, so no branch can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    table_d = table_q;
    mm_d    = mm_q;
    ff_d    = ff_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = expected;
          idx_d   = '0;
          cnt_d   = '0;
          table_d = '0;
          mm_d    = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == SETTLE_LAST) state_d = CAPTURE;
        else                      cnt_d   = cnt_q + 4'd1;
      end
      CAPTURE: begin
        table_d[idx_q] = dut_f;
        if (miss) begin
          mm_d = mm_q + (N_IN+1)'(1);
          if (mm_q == '0) ff_d = idx_q;
        end
        if (stop) begin
          // pass is settled here so it is already valid while done is high
          pass_d  = (mm_d == '0);
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + N_IN'(1);
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      mm_q    <= '0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      mm_q    <= mm_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
    end
  end

  assign dut_in       = idx_q;
  assign busy         = busy_q;
  assign done         = (state_q == FINISH);
  assign pass         = pass_q;
  assign table_out    = table_q;
  assign mismatch_cnt = mm_q;
  assign first_fail   = ff_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: a reference model fills a scoreboard when each sweep
// starts; entries are popped and compared when the sequencer raises done.
module tb_truth_table_sequencer;

  typedef struct {
    logic [15:0] tbl;
    logic        pass;
    logic [4:0]  cnt;
    logic [3:0]  ff;
    logic [3:0]  last_in;
    int          done_j;
  } res_t;

  res_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] exp_a = '0;
  logic [3:0]  exp_b = '0;
  int          f_sel = 0;
  bit          bsel  = 1'b0;

  logic [3:0]  in_a;   logic [1:0] in_b;
  logic        f_a, f_b;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0] tbl_a;  logic [3:0] tbl_b;
  logic [4:0]  cnt_a;  logic [2:0] cnt_b;
  logic [3:0]  ff_a;   logic [1:0] ff_b;

  logic [3:0]  mon_in;
  logic        mon_busy, mon_done, mon_pass;
  logic [15:0] mon_tbl;
  logic [4:0]  mon_cnt;
  logic [3:0]  mon_ff;

  always #5 clk = ~clk;

  // Functions under test: f=(a&b)|(c&d) or tied 0 for the wide instance, f=a^b for the small one
  assign f_a = (f_sel == 0) ? ((in_a[3] & in_a[2]) | (in_a[1] & in_a[0])) : 1'b0;
  assign f_b = in_b[1] ^ in_b[0];

  truth_table_sequencer #(.N_IN(4), .SETTLE(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a), .dut_in(in_a), .dut_f(f_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .table_out(tbl_a), .mismatch_cnt(cnt_a),
    .first_fail(ff_a));

  truth_table_sequencer #(.N_IN(2), .SETTLE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b), .dut_in(in_b), .dut_f(f_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .table_out(tbl_b), .mismatch_cnt(cnt_b),
    .first_fail(ff_b));

  assign mon_in   = bsel ? {2'b00, in_b}   : in_a;
  assign mon_busy = bsel ? busy_b          : busy_a;
  assign mon_done = bsel ? done_b          : done_a;
  assign mon_pass = bsel ? pass_b          : pass_a;
  assign mon_tbl  = bsel ? {12'h000, tbl_b} : tbl_a;
  assign mon_cnt  = bsel ? {2'b00, cnt_b}  : cnt_a;
  assign mon_ff   = bsel ? {2'b00, ff_b}   : ff_a;

  function automatic res_t model(input int n, input int settle, input logic [15:0] exp_tbl,
                                 input int fs);
    res_t r;
    r.tbl = '0; r.cnt = '0; r.ff = '0; r.last_in = '0; r.done_j = 0;
    for (int i = 0; i < (1 << n); i++) begin
      logic f;
      if (n == 2)       f = i[1] ^ i[0];
      else if (fs == 1) f = 1'b0;
      else              f = (i[3] & i[2]) | (i[1] & i[0]);
      r.tbl[i]  = f;
      r.last_in = i[3:0];
      r.done_j  = (i + 1) * (settle + 1);
      if (f !== exp_tbl[i]) begin
        if (r.cnt == 0) r.ff = i[3:0];
        r.cnt++;
`ifdef SEQ_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    r.pass = (r.cnt == 0);
    return r;
  endfunction

  // One sweep: start pulse, per-cycle dut_in/busy checks, scoreboard compare at done.
  task automatic run_sweep(input bit b, input logic [15:0] exp_tbl, input string name,
                           input int again_j, input int rst_j, input int watch);
    res_t e, r;
    int   per;
    bit   seen;
    per  = b ? 2 : 3;
    e    = model(b ? 2 : 4, per - 1, exp_tbl, f_sel);
    bsel = b;
    @(negedge clk);
    if (b) begin start_b = 1'b1; exp_b = exp_tbl[3:0]; end
    else   begin start_a = 1'b1; exp_a = exp_tbl; end
    sb_q.push_back(e);
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    seen = 1'b0;
    for (int j = 0; j <= e.done_j + 4 && !seen; j++) begin
      start_a = (j == again_j);
      if (j == rst_j) begin
        rst_n = 1'b0;
        #1;
        total++;
        if ({mon_in, mon_busy, mon_done, mon_pass, mon_tbl, mon_cnt, mon_ff} !== 31'h0) begin
          bad++;
          $display("FAIL %s async_reset: outputs=%h required=0", name,
                   {mon_in, mon_busy, mon_done, mon_pass, mon_tbl, mon_cnt, mon_ff});
        end
        void'(sb_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          total++;
          if (mon_done !== 1'b0 || mon_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s post_reset_idle: done=%b busy=%b required 0 0", name, mon_done, mon_busy);
          end
        end
        return;
      end
      if (mon_done === 1'b1) begin
        seen = 1'b1;
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL %s scoreboard: done seen with empty queue", name);
        end else begin
          r = sb_q.pop_front();
          total++;
          if (j !== r.done_j) begin
            bad++; $display("FAIL %s done_time: cycle=%0d required=%0d", name, j, r.done_j);
          end
          total++;
          if (mon_tbl !== r.tbl) begin
            bad++; $display("FAIL %s table_out: got=%h required=%h", name, mon_tbl, r.tbl);
          end
          total++;
          if (mon_pass !== r.pass) begin
            bad++; $display("FAIL %s pass: got=%b required=%b", name, mon_pass, r.pass);
          end
          total++;
          if (mon_cnt !== r.cnt) begin
            bad++; $display("FAIL %s mismatch_cnt: got=%0d required=%0d", name, mon_cnt, r.cnt);
          end
          total++;
          if (mon_ff !== r.ff) begin
            bad++; $display("FAIL %s first_fail: got=%0d required=%0d", name, mon_ff, r.ff);
          end
          total++;
          if (mon_busy !== 1'b1) begin
            bad++; $display("FAIL %s busy_in_finish: got=%b required=1", name, mon_busy);
          end
        end
      end else if (j < e.done_j) begin
        total++;
        if (mon_in !== 4'(j / per) || mon_busy !== 1'b1) begin
          bad++;
          $display("FAIL %s sweep_step j=%0d: dut_in=%0d busy=%b required dut_in=%0d busy=1",
                   name, j, mon_in, mon_busy, j / per);
        end
      end
      if (!seen) @(negedge clk);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s timeout: no done within %0d cycles", name, e.done_j + 4);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
      return;
    end
    @(negedge clk);
    total++;
    if (mon_busy !== 1'b0 || mon_done !== 1'b0) begin
      bad++; $display("FAIL %s after_finish: busy=%b done=%b required 0 0", name, mon_busy, mon_done);
    end
    for (int k = 0; k < watch; k++) begin
      @(negedge clk);
      total++;
      if (mon_done !== 1'b0 || mon_busy !== 1'b0) begin
        bad++; $display("FAIL %s extra_sweep: done=%b busy=%b required 0 0", name, mon_done, mon_busy);
      end
    end
    repeat (3) @(negedge clk);
    total++;
    if (mon_tbl !== e.tbl || mon_in !== e.last_in) begin
      bad++;
      $display("FAIL %s idle_hold: table=%h dut_in=%0d required table=%h dut_in=%0d",
               name, mon_tbl, mon_in, e.tbl, e.last_in);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({in_a, busy_a, done_a, pass_a, tbl_a, cnt_a, ff_a} !== 31'h0) begin
      bad++; $display("FAIL reset_a: outputs=%h required=0", {in_a, busy_a, done_a, pass_a, tbl_a, cnt_a, ff_a});
    end
    total++;
    if ({in_b, busy_b, done_b, pass_b, tbl_b, cnt_b, ff_b} !== 15'h0) begin
      bad++; $display("FAIL reset_b: outputs=%h required=0", {in_b, busy_b, done_b, pass_b, tbl_b, cnt_b, ff_b});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pass();
    f_sel = 0;
    run_sweep(1'b0, 16'hF888, "and_or_pass", -1, -1, 0);
  endtask

  task automatic test_single_fail();
    f_sel = 0;
    run_sweep(1'b0, 16'hF880, "and_or_one_miss", -1, -1, 0);
  endtask

  task automatic test_all_fail();
    f_sel = 1;
    run_sweep(1'b0, 16'hFFFF, "tied_zero", -1, -1, 0);
    f_sel = 0;
  endtask

  task automatic test_restart_ignored();
    run_sweep(1'b0, 16'hF888, "start_while_busy", 20, -1, 60);
  endtask

  task automatic test_reset_mid_sweep();
    run_sweep(1'b0, 16'hF888, "reset_mid", -1, 25, 0);
    run_sweep(1'b0, 16'hF888, "after_reset", -1, -1, 0);
  endtask

  task automatic test_back_to_back();
    res_t e, r;
    int   first_j, seen;
    bsel = 1'b0; f_sel = 0;
    e = model(4, 2, 16'hF888, 0);
    sb_q.push_back(e);
    sb_q.push_back(e);
    @(negedge clk);
    exp_a = 16'hF888; start_a = 1'b1;
    first_j = -1; seen = 0;
    for (int j = 0; j < 200 && seen < 2; j++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin
        seen++;
        r = sb_q.pop_front();
        total++;
        if (tbl_a !== r.tbl || pass_a !== r.pass) begin
          bad++; $display("FAIL b2b_result%0d: table=%h pass=%b required %h %b", seen, tbl_a, pass_a, r.tbl, r.pass);
        end
        if (seen == 1) first_j = j;
        else begin
          start_a = 1'b0;
          total++;
          if (j - first_j !== 50) begin
            bad++; $display("FAIL b2b_spacing: got=%0d required=50", j - first_j);
          end
        end
      end
    end
    start_a = 1'b0;
    total++;
    if (seen != 2) begin
      bad++; $display("FAIL b2b_timeout: dones=%0d required=2", seen);
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy_a !== 1'b0) begin
      bad++; $display("FAIL b2b_idle: busy=%b required=0", busy_a);
    end
  endtask

  task automatic test_small();
    run_sweep(1'b1, 16'h0006, "xor_n2", -1, -1, 0);
    bsel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_single_fail();
    test_all_fail();
    test_restart_ignored();
    test_reset_mid_sweep();
    test_back_to_back();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Clocked controller that exhaustively sweeps a combinational N-input function under test through all 2^N input codes.
- Captures the single-bit output for each code into a truth-table register and compares the result against an expected table.
- Reports pass/fail, mismatch count and first failing index.
- Sits between a lab top level (switches/LEDs or bench) and any single-output combinational exercise block; replaces hand-written exhaustive stimulus.

Parameters:
- N_IN, 4, number of DUT inputs; 2^N_IN vectors swept (legal 1..6).
- SETTLE, 2, cycles each vector is held before the output is sampled (legal 1..15).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin sweep; sampled only in IDLE
- expected  input  2^N_IN  golden truth table, bit i = required f for input code i; sampled at start
- dut_in  output  N_IN  drives DUT inputs; MSB = first operand (a), LSB = last (d)
- dut_f  input  1  DUT output
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse at sweep end
- pass  output  1  captured table equals expected; valid after done
- table_out  output  2^N_IN  captured truth table, bit i = dut_f for code i
- mismatch_cnt  output  N_IN+1  number of differing bits
- first_fail  output  N_IN  lowest failing code; 0 when mismatch_cnt==0

Behaviour:
- Reset (async, rst_n=0): state IDLE; dut_in=0, busy=0, done=0, pass=0, table_out=0, mismatch_cnt=0, first_fail=0, internal index/settle counter=0, expected copy=0.
- FSM states: IDLE, HOLD, CAPTURE, FINISH.
- IDLE:
  - start=1 at edge E0: latch expected, idx=0, dut_in=0, clear table_out/mismatch_cnt/first_fail/pass, busy=1, go to HOLD with settle counter=0.
- HOLD:
  - Counter increments each cycle.
  - When counter reaches SETTLE-1, go to CAPTURE.
- CAPTURE (one cycle):
  - On the exiting edge, table_out[idx] <= dut_f.
  - If dut_f != expected[idx]: mismatch_cnt increments; first_fail <= idx if this is the first mismatch.
  - If idx == 2^N_IN-1: go to FINISH.
  - Otherwise: idx++, dut_in <= idx+1, counter=0, go to HOLD.
- Timing:
  - Each vector is driven for exactly SETTLE+1 cycles.
  - Capture of code i occurs at edge E0+(i+1)*(SETTLE+1).
- FINISH (one cycle):
  - done=1; pass = (mismatch_cnt==0); busy drops to 0 on the edge leaving FINISH; return to IDLE.
  - For N_IN=4, SETTLE=2: done is high in the cycle following edge E0+48.
- start while busy: ignored, no restart.
- start held high continuously: a new sweep begins in the cycle after FINISH.
- Results (table_out, pass, mismatch_cnt, first_fail) hold in IDLE until the next accepted start.
- dut_in holds the last code (all ones) in IDLE after a sweep.
- rst_n low mid-sweep: immediate return to reset values; no done pulse.
- No wrap of mismatch_cnt: width N_IN+1 covers 2^N_IN.

Optional Feature:
- Macro SEQ_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CAPTURE goes directly to FINISH.
  - mismatch_cnt=1; first_fail = failing code; pass=0.
  - table_out bits above the failing index remain 0.
  - dut_in holds the failing code while in IDLE.
- Undefined: the full sweep always completes; all mismatches are counted.

Test Plan:
- DUT f=(a&b)|(c&d), expected=16'hF888, start pulse after reset -> dut_in steps 0..15 every 3 cycles; done one cycle after E0+48; table_out=16'hF888, pass=1, mismatch_cnt=0, first_fail=0.
- Same DUT, expected=16'hF880 -> table_out=16'hF888, pass=0, mismatch_cnt=1, first_fail=3; with SEQ_STOP_ON_FAIL_EN: done after E0+12, table_out=16'h0008.
- DUT tied f=0, expected=16'hFFFF -> mismatch_cnt=16 (5'b10000), first_fail=0, pass=0.
- start pulsed again at cycle 20 of a sweep -> ignored; exactly one done, at E0+48.
- rst_n low at cycle 25 of a sweep -> all outputs return to reset values asynchronously; no done; a subsequent start runs a clean full sweep.
- N_IN=2, SETTLE=1, DUT f=a^b, expected=4'b0110 -> done after E0+8, table_out=4'h6, pass=1.
